// File: rtl/reg_writeback_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter slice.
// Optional forwarding outputs are enabled by defining WB_FORWARD_EN.
package reg_writeback_arbiter_pkg;

  localparam int                    REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 5'd0;
  localparam int                    WB_DATA_W  = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

  // Register 0 is hardwired, so it never counts as a real destination hit.
  function automatic logic addr_hit(input logic [REG_ADDR_W-1:0] a,
                                    input logic [REG_ADDR_W-1:0] b);
    return (a == b) && (a != REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_writeback_arbiter_if.sv
// Execute/memory-side bundle of the writeback arbiter (slave = arbiter).
// Forwarding signals exist only when WB_FORWARD_EN is defined.
interface reg_writeback_arbiter_if
  import reg_writeback_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0]     alu_data;

  logic                  ldu_valid;
  logic                  ldu_ready;
  logic [REG_ADDR_W-1:0] ldu_addr;
  logic [DATA_W-1:0]     ldu_data;

  logic [REG_ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0]     wr_data;

  logic [REG_ADDR_W-1:0] q1_addr;
  logic [REG_ADDR_W-1:0] q2_addr;
  logic                  q1_pending;
  logic                  q2_pending;

`ifdef WB_FORWARD_EN
  logic                  q1_fwd_valid;
  logic [DATA_W-1:0]     q1_fwd_data;
  logic                  q2_fwd_valid;
  logic [DATA_W-1:0]     q2_fwd_data;

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  ldu_valid, ldu_addr, ldu_data,
    output ldu_ready,
    output wr_addr, wr_data,
    input  q1_addr, q2_addr,
    output q1_pending, q2_pending,
    output q1_fwd_valid, q1_fwd_data, q2_fwd_valid, q2_fwd_data
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output ldu_valid, ldu_addr, ldu_data,
    input  ldu_ready,
    input  wr_addr, wr_data,
    output q1_addr, q2_addr,
    input  q1_pending, q2_pending,
    input  q1_fwd_valid, q1_fwd_data, q2_fwd_valid, q2_fwd_data
  );
`else
  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  ldu_valid, ldu_addr, ldu_data,
    output ldu_ready,
    output wr_addr, wr_data,
    input  q1_addr, q2_addr,
    output q1_pending, q2_pending
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output ldu_valid, ldu_addr, ldu_data,
    input  ldu_ready,
    input  wr_addr, wr_data,
    output q1_addr, q2_addr,
    input  q1_pending, q2_pending
  );
`endif

endinterface

// File: rtl/reg_writeback_arbiter_wb_queue.sv
// In-order load-result circular buffer with squash-by-address and age-ordered
// address-match vectors; age-ordered data is exported when WB_FORWARD_EN is defined.
module wb_queue
  import reg_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  push_valid_i,
  input  logic [REG_ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0]     push_data_i,
  input  logic                  pop_i,
  input  logic                  squash_i,
  input  logic [REG_ADDR_W-1:0] squash_addr_i,
  input  logic [REG_ADDR_W-1:0] q1_addr_i,
  input  logic [REG_ADDR_W-1:0] q2_addr_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  head_valid_o,
  output logic [REG_ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0]     head_data_o,
  output logic [DEPTH-1:0]      q1_match_o,
  output logic [DEPTH-1:0]      q2_match_o
`ifdef WB_FORWARD_EN
  ,
  output logic [DATA_W-1:0]     age_data_o [DEPTH]
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [REG_ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];
  logic [IDX_W-1:0]      rd_idx, wr_idx;

  assign rd_idx  = rd_ptr_q[IDX_W-1:0];
  assign wr_idx  = wr_ptr_q[IDX_W-1:0];
  assign empty_o = (rd_ptr_q == wr_ptr_q);
  assign full_o  = (rd_idx == wr_idx) && (rd_ptr_q[IDX_W] != wr_ptr_q[IDX_W]);

  assign head_valid_o = valid_q[rd_idx];
  assign head_addr_o  = addr_q[rd_idx];
  assign head_data_o  = data_q[rd_idx];

  // Pop clears before push sets, so a full-queue push can reuse the popped slot.
  always_comb begin
    valid_d = valid_q;
    if (squash_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == squash_addr_i) valid_d[i] = 1'b0;
      end
    end
    if (pop_i)  valid_d[rd_idx] = 1'b0;
    if (push_i) valid_d[wr_idx] = push_valid_i;
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[wr_idx] <= push_addr_i;
      data_q[wr_idx] <= push_data_i;
    end
  end

  // Index 0 is the head (oldest); higher indices are younger entries.
  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    logic [IDX_W-1:0] slot;
    assign slot          = rd_idx + IDX_W'(g);
    assign q1_match_o[g] = valid_q[slot] && addr_hit(addr_q[slot], q1_addr_i);
    assign q2_match_o[g] = valid_q[slot] && addr_hit(addr_q[slot], q2_addr_i);
`ifdef WB_FORWARD_EN
    assign age_data_o[g] = data_q[slot];
`endif
  end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Merges ALU and load/MDU results into the single register-file write port.
// Define WB_FORWARD_EN to add youngest-queued-value forwarding outputs.
module reg_writeback_arbiter
  import reg_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  reg_writeback_arbiter_if.slave  bus_if
);

  logic                  alu_wr;
  logic                  ld_nz;
  logic                  ldu_ready;
  logic                  accept;
  logic                  bypass;
  logic                  pop;
  logic                  push;
  logic                  push_valid;
  logic                  full;
  logic                  empty;
  logic                  head_valid;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0]     head_data;
  logic [DEPTH-1:0]      q1_match;
  logic [DEPTH-1:0]      q2_match;
  logic                  ld_hit1;
  logic                  ld_hit2;

  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;

`ifdef WB_FORWARD_EN
  logic [DATA_W-1:0]     age_data [DEPTH];
`endif

  assign alu_wr     = bus_if.alu_valid && (bus_if.alu_addr != REG_ZERO);
  assign ld_nz      = (bus_if.ldu_addr != REG_ZERO);
  assign pop        = !alu_wr && !empty;
  assign ldu_ready  = !full || pop;
  assign accept     = bus_if.ldu_valid && ldu_ready;
  // An idle port with an empty queue lets a load skip the queue entirely.
  assign bypass     = accept && ld_nz && !alu_wr && empty;
  assign push       = accept && ld_nz && !bypass;
  assign push_valid = !(alu_wr && (bus_if.ldu_addr == bus_if.alu_addr));

  assign bus_if.ldu_ready = ldu_ready;

  wb_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_queue (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (push),
    .push_valid_i  (push_valid),
    .push_addr_i   (bus_if.ldu_addr),
    .push_data_i   (bus_if.ldu_data),
    .pop_i         (pop),
    .squash_i      (alu_wr),
    .squash_addr_i (bus_if.alu_addr),
    .q1_addr_i     (bus_if.q1_addr),
    .q2_addr_i     (bus_if.q2_addr),
    .full_o        (full),
    .empty_o       (empty),
    .head_valid_o  (head_valid),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data),
    .q1_match_o    (q1_match),
    .q2_match_o    (q2_match)
`ifdef WB_FORWARD_EN
    ,
    .age_data_o    (age_data)
`endif
  );

  always_comb begin
    wr_addr_d = REG_ZERO;
    wr_data_d = '0;
    if (alu_wr) begin
      wr_addr_d = bus_if.alu_addr;
      wr_data_d = bus_if.alu_data;
    end else if (pop) begin
      // A squashed head still drains its slot but writes nothing.
      if (head_valid) begin
        wr_addr_d = head_addr;
        wr_data_d = head_data;
      end
    end else if (bypass) begin
      wr_addr_d = bus_if.ldu_addr;
      wr_data_d = bus_if.ldu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q <= REG_ZERO;
      wr_data_q <= '0;
    end else begin
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus_if.wr_addr = wr_addr_q;
  assign bus_if.wr_data = wr_data_q;

  assign ld_hit1 = accept && addr_hit(bus_if.ldu_addr, bus_if.q1_addr);
  assign ld_hit2 = accept && addr_hit(bus_if.ldu_addr, bus_if.q2_addr);

  assign bus_if.q1_pending = (|q1_match) || ld_hit1;
  assign bus_if.q2_pending = (|q2_match) || ld_hit2;

`ifdef WB_FORWARD_EN
  logic [DATA_W-1:0] fwd1, fwd2;

  // Later (younger) matches override earlier ones; the arriving beat is youngest.
  always_comb begin
    fwd1 = '0;
    fwd2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q1_match[i]) fwd1 = age_data[i];
      if (q2_match[i]) fwd2 = age_data[i];
    end
    if (ld_hit1) fwd1 = bus_if.ldu_data;
    if (ld_hit2) fwd2 = bus_if.ldu_data;
  end

  assign bus_if.q1_fwd_valid = (|q1_match) || ld_hit1;
  assign bus_if.q2_fwd_valid = (|q2_match) || ld_hit2;
  assign bus_if.q1_fwd_data  = fwd1;
  assign bus_if.q2_fwd_data  = fwd2;
`endif

endmodule
